ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 192 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// The host holds ps2c low for a request-to-send interval, then shifts out
// 8 data bits LSB-first plus odd parity on the device-generated clock. It
// then releases the data line for the stop bit and waits for the ack clock.
// Both PS/2 lines are open-drain: they are only ever driven low or released.
// Optional build macro: PS2_TX_ACK_CHECK_EN. When it is defined, a device that
// leaves ps2d high at the ack clock is reported on tx_err instead of tx_done_tick.
module ps2_host_tx #(
  parameter int RTS_CYCLES     = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  inout  wire        ps2d,
  inout  wire        ps2c,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err
);

  localparam int CNT_MAX = (RTS_CYCLES > TIMEOUT_CYCLES) ? RTS_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, RTS, START, DATA, STOP, ACK} state_t;

  // Odd parity: the parity bit makes the total number of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  state_t          state_r, state_n;
  logic [8:0]      shreg_r, shreg_n;
  logic [3:0]      bit_cnt_r, bit_cnt_n;
  logic [CW-1:0]   cnt_r, cnt_n;
  logic [7:0]      filt_sr_r, filt_sr_n;
  logic            filt_r, filt_n;
  logic            fall_s;
  logic            wd_hit_s;
  logic            c_drv_r, c_drv_n;
  logic            d_drv_r, d_drv_n;
  logic            idle_n, done_n, err_n;
`ifdef PS2_TX_ACK_CHECK_EN
  logic            ps2d_s;
  assign ps2d_s = ps2d;
`endif

  // Open-drain line drivers: pull low or release to the external pull-up.
  assign ps2c = c_drv_r ? 1'b0 : 1'bz;
  assign ps2d = d_drv_r ? 1'b0 : 1'bz;

  // Glitch filter on the device clock and falling-edge detection.
  always_comb begin
    filt_sr_n = {ps2c, filt_sr_r[7:1]};
    if (filt_sr_n == 8'hFF) begin
      filt_n = 1'b1;
    end else if (filt_sr_n == 8'h00) begin
      filt_n = 1'b0;
    end else begin
      filt_n = filt_r;
    end
    fall_s   = filt_r & ~filt_n;
    wd_hit_s = (cnt_r == CW'(TIMEOUT_CYCLES - 1));
  end

  // Next-state logic, frame shifting, watchdog and registered output values.
  always_comb begin
    state_n   = state_r;
    shreg_n   = shreg_r;
    bit_cnt_n = bit_cnt_r;
    cnt_n     = cnt_r;
    done_n    = 1'b0;
    err_n     = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_n = '0;
        if (wr_ps2) begin
          shreg_n = {odd_parity(din), din};
          state_n = RTS;
        end else begin
          state_n = IDLE;
        end
      end
      RTS: begin
        if (cnt_r == CW'(RTS_CYCLES - 1)) begin
          cnt_n   = '0;
          state_n = START;
        end else begin
          cnt_n = cnt_r + CW'(1);
        end
      end
      START: begin
        if (fall_s) begin
          cnt_n     = '0;
          bit_cnt_n = 4'd9;
          state_n   = DATA;
        end else if (wd_hit_s) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt_r + CW'(1);
        end
      end
      DATA: begin
        if (fall_s) begin
          cnt_n     = '0;
          shreg_n   = {1'b0, shreg_r[8:1]};
          bit_cnt_n = bit_cnt_r - 4'd1;
          if (bit_cnt_r == 4'd1) begin
            state_n = STOP;
          end else begin
            state_n = DATA;
          end
        end else if (wd_hit_s) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt_r + CW'(1);
        end
      end
      STOP: begin
        if (fall_s) begin
          cnt_n   = '0;
          state_n = ACK;
        end else if (wd_hit_s) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt_r + CW'(1);
        end
      end
      ACK: begin
        if (fall_s) begin
          cnt_n   = '0;
          state_n = IDLE;
`ifdef PS2_TX_ACK_CHECK_EN
          if (ps2d_s) begin
            err_n = 1'b1;
          end else begin
            done_n = 1'b1;
          end
`else
          done_n = 1'b1;
`endif
        end else if (wd_hit_s) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt_r + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    c_drv_n = (state_n == RTS);
    d_drv_n = (state_n == START) || ((state_n == DATA) && !shreg_n[0]);
    idle_n  = (state_n == IDLE);
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= IDLE;
      shreg_r      <= 9'd0;
      bit_cnt_r    <= 4'd0;
      cnt_r        <= '0;
      filt_sr_r    <= 8'hFF;
      filt_r       <= 1'b1;
      c_drv_r      <= 1'b0;
      d_drv_r      <= 1'b0;
      tx_idle      <= 1'b1;
      tx_done_tick <= 1'b0;
      tx_err       <= 1'b0;
    end else begin
      state_r      <= state_n;
      shreg_r      <= shreg_n;
      bit_cnt_r    <= bit_cnt_n;
      cnt_r        <= cnt_n;
      filt_sr_r    <= filt_sr_n;
      filt_r       <= filt_n;
      c_drv_r      <= c_drv_n;
      d_drv_r      <= d_drv_n;
      tx_idle      <= idle_n;
      tx_done_tick <= done_n;
      tx_err       <= err_n;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a PS/2 device model clocks frames out
// of the host and records the bits it samples on each rising clock edge.
// A timing model predicts tx_idle/tx_done_tick/tx_err and the ps2c level for
// every cycle. Build with PS2_TX_ACK_CHECK_EN to expect ack checking.
module tb_ps2_host_tx;

  localparam int RTS = 50;
  localparam int TO  = 400;
  localparam int H   = 20;   // device clock half period in clk cycles

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dev_c_low = 1'b0;
  logic       dev_d_low = 1'b0;
  logic       tx_idle, tx_done_tick, tx_err;
  wire        ps2c, ps2d;

  pullup (ps2c);
  pullup (ps2d);
  assign ps2c = dev_c_low ? 1'b0 : 1'bz;
  assign ps2d = dev_d_low ? 1'b0 : 1'bz;

  // Model expectations for the cycle following the next rising clk edge.
  logic exp_idle = 1'b1, exp_done = 1'b0, exp_err = 1'b0, exp_host_c = 1'b0;
  logic chk_en = 1'b0;
  int   errors = 0, checks = 0;
  int   done_cnt = 0, err_cnt = 0;

  ps2_host_tx #(.RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .wr_ps2(wr_ps2), .din(din),
    .ps2d(ps2d), .ps2c(ps2c),
    .tx_idle(tx_idle), .tx_done_tick(tx_done_tick), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Cycle-by-cycle comparison of DUT outputs against the model.
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      check("tx_idle", tx_idle, exp_idle);
      check("tx_done_tick", tx_done_tick, exp_done);
      check("tx_err", tx_err, exp_err);
      check("ps2c_line", ps2c, (exp_host_c || dev_c_low) ? 32'd0 : 32'd1);
      if (tx_done_tick === 1'b1) done_cnt++;
      if (tx_err === 1'b1) err_cnt++;
    end
  end

  // Issue a write; the host must hold ps2c low for exactly RTS cycles.
  task automatic host_write(input logic [7:0] b);
    @(negedge clk);
    wr_ps2 = 1'b1; din = b; exp_idle = 1'b0; exp_host_c = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0; din = ~b;
    repeat (RTS - 1) @(negedge clk);
    exp_host_c = 1'b0;
  endtask

  // Device side: 12 clock pulses, sample data at each of the first 10 rises.
  task automatic dev_xfer(input logic [7:0] b, input logic ack_low, input int abort_after,
                          input logic inject, output logic [9:0] samp);
    logic [9:0] bits;
    bits = {1'b1, ~^b, b};
    samp = 10'd0;
    repeat (2 * H) @(negedge clk);
    check("start_bit", ps2d, 32'd0);
    for (int i = 1; i <= 12; i++) begin
      dev_c_low = 1'b1;
      if (i == 12) begin
        repeat (7) @(negedge clk);
        exp_idle = 1'b1;
`ifdef PS2_TX_ACK_CHECK_EN
        if (ack_low) exp_done = 1'b1; else exp_err = 1'b1;
`else
        exp_done = 1'b1;
`endif
        @(negedge clk);
        exp_done = 1'b0; exp_err = 1'b0;
        repeat (H - 8) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
      if (i <= 10) begin
        samp[i-1] = ps2d;
        check("dev_bit", ps2d, bits[i-1]);
      end
      dev_c_low = 1'b0;
      if (i == 11) dev_d_low = ack_low;
      if (i == 12) dev_d_low = 1'b0;
      if (i == abort_after) begin
        repeat (5) @(negedge clk);
        break;
      end
      if (inject && i == 3) begin
        @(negedge clk);
        wr_ps2 = 1'b1; din = 8'hAA;
        @(negedge clk);
        wr_ps2 = 1'b0;
        repeat (H - 2) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [9:0] samp;
    int d0, e0;
    repeat (3) @(negedge clk);
    check("rst_idle", tx_idle, 32'd1);
    check("rst_done", tx_done_tick, 32'd0);
    check("rst_err", tx_err, 32'd0);
    check("rst_ps2c", ps2c, 32'd1);
    check("rst_ps2d", ps2d, 32'd1);
    reset = 1'b1;
    chk_en = 1'b1;
    repeat (5) @(negedge clk);

    // 0xF4 with ack
    d0 = done_cnt; e0 = err_cnt;
    host_write(8'hF4);
    dev_xfer(8'hF4, 1'b1, 0, 1'b0, samp);
    check("f4_frame", samp, 32'h2F4);
    check("f4_done", done_cnt - d0, 32'd1);
    check("f4_err", err_cnt - e0, 32'd0);

    // 0x00: parity bit 1
    d0 = done_cnt; e0 = err_cnt;
    host_write(8'h00);
    dev_xfer(8'h00, 1'b1, 0, 1'b0, samp);
    check("z_frame", samp, 32'h300);
    check("z_done", done_cnt - d0, 32'd1);

    // device leaves ps2d high at ack
    d0 = done_cnt; e0 = err_cnt;
    host_write(8'h5A);
    dev_xfer(8'h5A, 1'b0, 0, 1'b0, samp);
    check("nack_frame", samp, 32'h35A);
`ifdef PS2_TX_ACK_CHECK_EN
    check("nack_done", done_cnt - d0, 32'd0);
    check("nack_err", err_cnt - e0, 32'd1);
`else
    check("nack_done", done_cnt - d0, 32'd1);
    check("nack_err", err_cnt - e0, 32'd0);
`endif

    // device never clocks: timeout TO cycles after START entry
    d0 = done_cnt; e0 = err_cnt;
    host_write(8'h3C);
    repeat (TO) @(negedge clk);
    exp_idle = 1'b1; exp_err = 1'b1;
    @(negedge clk);
    exp_err = 1'b0;
    check("to_ps2d", ps2d, 32'd1);
    check("to_ps2c", ps2c, 32'd1);
    check("to_err", err_cnt - e0, 32'd1);
    check("to_done", done_cnt - d0, 32'd0);
    repeat (20) @(negedge clk);

    // reset after the 4th data bit
    d0 = done_cnt; e0 = err_cnt;
    host_write(8'h96);
    dev_xfer(8'h96, 1'b1, 4, 1'b0, samp);
    reset = 1'b0; exp_idle = 1'b1;
    @(negedge clk);
    check("rst_mid_ps2d", ps2d, 32'd1);
    check("rst_mid_ps2c", ps2c, 32'd1);
    check("rst_mid_idle", tx_idle, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_mid_pulses", (done_cnt - d0) + (err_cnt - e0), 32'd0);

    // 0xFF after the aborted frame
    d0 = done_cnt;
    host_write(8'hFF);
    dev_xfer(8'hFF, 1'b1, 0, 1'b0, samp);
    check("ff_frame", samp, 32'h3FF);
    check("ff_done", done_cnt - d0, 32'd1);

    // second write of 0xAA during DATA is ignored
    d0 = done_cnt; e0 = err_cnt;
    host_write(8'h31);
    dev_xfer(8'h31, 1'b1, 0, 1'b1, samp);
    check("inj_frame", samp, 32'h231);
    check("inj_done", done_cnt - d0, 32'd1);
    repeat (RTS + 20) @(negedge clk);
    check("inj_idle_after", tx_idle, 32'd1);
    check("inj_err", err_cnt - e0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
